serial_addsub: RTL and testbench

Bit-serial add/subtract unit. It takes two WIDTH-bit operands over a valid/ready handshake and processes one bit per clock, LSB first, through a single full_adder_1bit cell plus a carry flip-flop. It returns the sum or difference with carry, signed-overflow and zero flags over a second valid/ready handshake. It is the area-minimal, sequential counterpart to the team's parallel ripple-carry adder, for use where throughput is not critical.

---
 rtl/serial_addsub_pkg.sv | 13 +
 rtl/full_adder_1bit.sv | 13 +
 rtl/serial_addsub.sv | 101 ++++++++++
 tb/tb_serial_addsub.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types and opcode constants for the bit-serial add/subtract unit.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder_1bit.sv
// Single-bit full adder cell shared by the ripple and bit-serial adders.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: one full adder plus a carry flop, LSB first,
// with valid/ready handshakes on both the operand and result sides.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             sub,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] res_next;

  full_adder_1bit u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c_in  (carry),
    .sum   (fa_sum),
    .c_out (fa_cout)
  );

  // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands at the LSB.
  assign res_next    = {fa_sum, res_sh[WIDTH-1:1]};
  assign start_ready = (state == IDLE) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      a_sh         <= '0;
      b_sh         <= '0;
      res_sh       <= '0;
      carry        <= 1'b0;
      cnt          <= '0;
      result       <= '0;
      c_out        <= 1'b0;
      overflow     <= 1'b0;
      zero         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_valid) begin
            // Subtraction is A + ~B + 1; the +1 rides in as the initial carry.
            a_sh  <= a_in;
            b_sh  <= (sub == OP_SUB) ? ~b_in : b_in;
            carry <= sub;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next;
          carry  <= fa_cout;
          if (cnt == LAST_BIT) begin
            result       <= res_next;
            c_out        <= fa_cout;
            overflow     <= carry ^ fa_cout;
            zero         <= (res_next == '0);
            result_valid <= 1'b1;
            state        <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub (WIDTH=4) with directed vectors.
`timescale 1ns/1ps
module tb_serial_addsub;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         ov;
    logic         z;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         sub = 1'b0;
  logic         result_valid;
  logic         result_ready = 1'b1;
  logic [W-1:0] result;
  logic         c_out;
  logic         overflow;
  logic         zero;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  logic prev_rv = 1'b0;
  exp_t sb_q[$];

  serial_addsub #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .a_in         (a_in),
    .b_in         (b_in),
    .sub          (sub),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .c_out        (c_out),
    .overflow     (overflow),
    .zero         (zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: latency on each rising result_valid, data on each handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && result_valid && !prev_rv)
      chk("latency", cyc - accept_cyc, W);
    prev_rv = result_valid;
    if (!reset && result_valid && result_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("result",   int'(result),   int'(e.res));
        chk("c_out",    int'(c_out),    int'(e.c));
        chk("overflow", int'(overflow), int'(e.ov));
        chk("zero",     int'(zero),     int'(e.z));
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [W-1:0] r, input logic c, input logic ov,
                       input logic z, input bit push);
    int n;
    exp_t e;
    @(posedge clk); #1;
    a_in = a; b_in = b; sub = s; start_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!start_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!start_ready) begin
      chk("start_ready_timeout", 0, 1);
      @(posedge clk); #1;
      start_valid = 1'b0;
      return;
    end
    if (push) begin
      e.res = r; e.c = c; e.ov = ov; e.z = z;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    accept_cyc  = cyc;
    start_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", sb_q.size(), 0);
  endtask

  initial begin
    int   n;
    int   rv_seen;
    exp_t e;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_start_ready", int'(start_ready), 0);
    chk("rst_result_valid", int'(result_valid), 0);
    chk("rst_result", int'(result), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("start_ready_after_rst", int'(start_ready), 1);

    // Directed vectors: a, b, sub, result, c_out, overflow, zero
    issue(4'd5,  4'd3, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1);
    issue(4'd7,  4'd7, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1);
    issue(4'd3,  4'd5, 1'b1, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4'd15, 4'd1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1);
    issue(4'd8,  4'd1, 1'b1, 4'b0111, 1'b1, 1'b1, 1'b0, 1'b1);
    issue(4'd2,  4'd6, 1'b1, 4'b1100, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4'd0,  4'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();

    // Backpressure: 6+7 = 13, signed overflow, held in DONE for 5 cycles
    @(posedge clk); #1;
    result_ready = 1'b0;
    issue(4'd6, 4'd7, 1'b0, 4'd13, 1'b0, 1'b1, 1'b0, 1'b1);
    n = 0;
    @(negedge clk);
    while (!result_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_result_valid", int'(result_valid), 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      start_valid = 1'b1;
      a_in = k[0] ? 4'hF : 4'h1;
      b_in = 4'h2;
      sub  = k[0];
      @(negedge clk);
      chk("bp_hold_result", int'(result), 13);
      chk("bp_hold_c_out", int'(c_out), 0);
      chk("bp_hold_overflow", int'(overflow), 1);
      chk("bp_hold_zero", int'(zero), 0);
      chk("bp_start_ready", int'(start_ready), 0);
      chk("bp_hold_valid", int'(result_valid), 1);
    end
    // Next op (0+0) held on the bus; it is accepted one cycle after IDLE returns.
    @(posedge clk); #1;
    a_in = 4'd0; b_in = 4'd0; sub = 1'b0;
    e.res = 4'd0; e.c = 1'b0; e.ov = 1'b0; e.z = 1'b1;
    sb_q.push_back(e);
    result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle_start_ready", int'(start_ready), 1);
    chk("bp_idle_valid_low", int'(result_valid), 0);
    @(posedge clk); #1;
    accept_cyc  = cyc;
    start_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_accepted", int'(start_ready), 0);
    drain();

    // Nonzero result so the reset check below has something to clear
    issue(4'd9, 4'd12, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    drain();

    // Reset after two bits of a RUN
    issue(4'd9, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrun_rst_valid", int'(result_valid), 0);
    chk("midrun_rst_result", int'(result), 0);
    chk("midrun_rst_c_out", int'(c_out), 0);
    chk("midrun_rst_overflow", int'(overflow), 0);
    chk("midrun_rst_zero", int'(zero), 0);
    chk("midrun_rst_start_ready", int'(start_ready), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_start_ready", int'(start_ready), 1);
    rv_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (result_valid) rv_seen++;
    end
    chk("no_result_after_rst", rv_seen, 0);

    // Operands changed after accept must not matter: 4-1 = 3
    issue(4'd4, 4'd1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    a_in = 4'hF; b_in = 4'hF; sub = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
